// File: rtl/event_encoder_8to3.sv
// event_encoder_8to3
// Sequential 8-to-3 priority encoder. Events on D are merged into a pending
// register, and the highest-priority pending index is offered on A with a
// valid/ready handshake. Each accepted code retires its pending bit, and the
// encoder idles for one bubble cycle before offering the next code.
// HIGH_FIRST selects whether D[7] (1) or D[0] (0) has the highest priority.

module event_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] D,
  input  logic       ready,
  output logic [2:0] A,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  logic       accept;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] dup_mask;
  logic [2:0] prio_idx;
  logic       any_pending;

  // New requests, retirement of the accepted code, and duplicate detection.
  // A duplicate is a new request on a bit that stays pending after this cycle.
  always_comb begin
    accept      = valid & ready;
    set_mask    = D & {8{en}};
    clr_mask    = accept ? (8'd1 << A) : 8'd0;
    dup_mask    = set_mask & pending & ~clr_mask;
    any_pending = |pending;
  end

  // Priority index taken from the registered pending value. The last match
  // in the loop wins, so the scan direction sets the priority order.
  always_comb begin
    prio_idx = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pending[i]) prio_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending[i]) prio_idx = 3'(i);
      end
    end
  end

  // Pending register and duplicate-request pulse. A set overrides a clear on
  // the same bit, so a code re-requested as it is accepted stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~clr_mask) | set_mask;
      overflow <= |dup_mask;
    end
  end

  // Handshake FSM. A is latched on entry to HOLD and stays frozen until the
  // consumer accepts it, even if a higher-priority request arrives meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      A     <= 3'd0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            A     <= prio_idx;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// tb_event_encoder_8to3
// Directed bench for event_encoder_8to3. Two instances share the stimulus:
// one with D[7] highest priority and one with D[0] highest priority.

module tb_event_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] d_in;
  logic       ready;

  logic [2:0] a_hi;
  logic       valid_hi;
  logic [7:0] pending_hi;
  logic       overflow_hi;

  logic [2:0] a_lo;
  logic       valid_lo;
  logic [7:0] pending_lo;
  logic       overflow_lo;

  int check_count = 0;
  int error_count = 0;

  event_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .D        (d_in),
    .ready    (ready),
    .A        (a_hi),
    .valid    (valid_hi),
    .pending  (pending_hi),
    .overflow (overflow_hi)
  );

  event_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .D        (d_in),
    .ready    (ready),
    .A        (a_lo),
    .valid    (valid_lo),
    .pending  (pending_lo),
    .overflow (overflow_lo)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic e, input logic r);
    d_in  = d;
    en    = e;
    ready = r;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] starting event_encoder_8to3 bench");
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b1, 1'b1);

    // Reset held across an edge with all requests active.
    #12;
    checkOutput("rst_pending", 32'(pending_hi), 32'h00);
    checkOutput("rst_valid", 32'(valid_hi), 32'd0);
    checkOutput("rst_a", 32'(a_hi), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_hi), 32'd0);
    rst_n = 1'b1;

    // First edge after release captures FF; valid follows one edge later.
    tick();
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("rel_pending", 32'(pending_hi), 32'hFF);
    checkOutput("rel_valid_early", 32'(valid_hi), 32'd0);
    tick();

    // Full drain of FF with ready=1: eight codes in priority order.
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("ff_valid_%0d", k), 32'(valid_hi), 32'd1);
      checkOutput($sformatf("ff_a_hi_%0d", k), 32'(a_hi), 32'(7 - k));
      checkOutput($sformatf("ff_a_lo_%0d", k), 32'(a_lo), 32'(k));
      tick();
      checkOutput($sformatf("ff_bubble_%0d", k), 32'(valid_hi), 32'd0);
      checkOutput($sformatf("ff_ovf_%0d", k), 32'(overflow_hi), 32'd0);
      tick();
    end
    checkOutput("ff_done_pending", 32'(pending_hi), 32'h00);
    checkOutput("ff_done_valid", 32'(valid_hi), 32'd0);

    // Single event: D=20 for one cycle.
    applyStimulus(8'h20, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("single_pending", 32'(pending_hi), 32'h20);
    checkOutput("single_valid_early", 32'(valid_hi), 32'd0);
    tick();
    checkOutput("single_valid", 32'(valid_hi), 32'd1);
    checkOutput("single_a", 32'(a_hi), 32'd5);
    tick();
    checkOutput("single_valid_drop", 32'(valid_hi), 32'd0);
    checkOutput("single_pending_clr", 32'(pending_hi), 32'h00);
    tick();
    checkOutput("single_valid_once", 32'(valid_hi), 32'd0);

    // Priority order with D=81 under both priority settings.
    applyStimulus(8'h81, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("prio_first_hi", 32'(a_hi), 32'd7);
    checkOutput("prio_first_lo", 32'(a_lo), 32'd0);
    checkOutput("prio_first_vlo", 32'(valid_lo), 32'd1);
    tick();
    checkOutput("prio_rem_hi", 32'(pending_hi), 32'h01);
    checkOutput("prio_rem_lo", 32'(pending_lo), 32'h80);
    tick();
    checkOutput("prio_second_hi", 32'(a_hi), 32'd0);
    checkOutput("prio_second_lo", 32'(a_lo), 32'd7);
    tick();
    checkOutput("prio_empty", 32'(pending_lo), 32'h00);

    // Backpressure: A=2 stays frozen while a higher request arrives.
    applyStimulus(8'h04, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("bp_valid", 32'(valid_hi), 32'd1);
    checkOutput("bp_a", 32'(a_hi), 32'd2);
    tick();
    applyStimulus(8'h40, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b0);
    checkOutput("bp_pending", 32'(pending_hi), 32'h44);
    checkOutput("bp_a_frozen", 32'(a_hi), 32'd2);
    tick();
    checkOutput("bp_a_still", 32'(a_hi), 32'd2);
    checkOutput("bp_valid_still", 32'(valid_hi), 32'd1);
    applyStimulus(8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("bp_accept_valid", 32'(valid_hi), 32'd0);
    checkOutput("bp_accept_pending", 32'(pending_hi), 32'h40);
    tick();
    checkOutput("bp_next_a", 32'(a_hi), 32'd6);
    checkOutput("bp_next_valid", 32'(valid_hi), 32'd1);
    tick();
    checkOutput("bp_empty", 32'(pending_hi), 32'h00);

    // Overflow: two duplicates of D[3] while pending give two pulses.
    applyStimulus(8'h08, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_first_none", 32'(overflow_hi), 32'd0);
    applyStimulus(8'h08, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_pulse1", 32'(overflow_hi), 32'd1);
    checkOutput("ovf_a", 32'(a_hi), 32'd3);
    applyStimulus(8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_gap", 32'(overflow_hi), 32'd0);
    applyStimulus(8'h08, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_pulse2", 32'(overflow_hi), 32'd1);
    checkOutput("ovf_pending", 32'(pending_hi), 32'h08);
    applyStimulus(8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_end", 32'(overflow_hi), 32'd0);

    // Re-request in the accept cycle: bit survives, no overflow.
    applyStimulus(8'h08, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b1);
    checkOutput("rereq_pending", 32'(pending_hi), 32'h08);
    checkOutput("rereq_ovf", 32'(overflow_hi), 32'd0);
    checkOutput("rereq_valid", 32'(valid_hi), 32'd0);
    tick();
    checkOutput("rereq_reissue_v", 32'(valid_hi), 32'd1);
    checkOutput("rereq_reissue_a", 32'(a_hi), 32'd3);
    tick();
    checkOutput("rereq_empty", 32'(pending_hi), 32'h00);

    // en=0: no capture, but a pending code still drains.
    applyStimulus(8'h10, 1'b0, 1'b1);
    tick();
    checkOutput("en0_no_capture", 32'(pending_hi), 32'h00);
    applyStimulus(8'h02, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("en0_a", 32'(a_hi), 32'd1);
    applyStimulus(8'h04, 1'b0, 1'b1);
    tick();
    checkOutput("en0_drain", 32'(pending_hi), 32'h00);
    checkOutput("en0_drain_valid", 32'(valid_hi), 32'd0);

    // Asynchronous reset while a code is held.
    applyStimulus(8'h02, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("async_pre_valid", 32'(valid_hi), 32'd1);
    checkOutput("async_pre_a", 32'(a_hi), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(valid_hi), 32'd0);
    checkOutput("async_pending", 32'(pending_hi), 32'h00);
    checkOutput("async_a", 32'(a_hi), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("async_after", 32'(valid_hi), 32'd0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
